pipe_skid_buffer: RTL and testbench

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

---
 rtl/pipe_skid_buffer_pkg.sv | 19 +
 rtl/pipe_skid_buffer.sv | 94 +++++++++
 tb/tb_pipe_skid_buffer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_buffer_pkg.sv
// Shared definitions for the two-entry pipeline skid buffer.
// Holds the occupancy state encoding and its mapping to an entry count.
package pipe_skid_buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  function automatic logic [1:0] state_count(input skid_state_t s);
    case (s)
      ONE:     state_count = 2'd1;
      TWO:     state_count = 2'd2;
      default: state_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer: a main register drives data_o directly, and a skid register
// catches one extra payload while downstream stalls.
module pipe_skid_buffer
  import pipe_skid_buffer_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pwrEn_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             stall_i,
  output logic [1:0]       count_o
);

  skid_state_t      state_q;
  skid_state_t      state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             release_main;
  logic             main_load;
  logic             main_from_skid;
  logic             skid_load;

  assign ready_o      = ~reset & pwrEn_i & (state_q != TWO);
  assign valid_o      = pwrEn_i & (state_q != EMPTY);
  assign data_o       = main_q;
  assign count_o      = state_count(state_q);
  assign accept       = valid_i & ready_o;
  assign release_main = valid_o & ~stall_i;

  always_comb begin
    state_next     = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          main_load  = 1'b1;
        end
      end
      ONE: begin
        if (accept && release_main) begin
          main_load = 1'b1;
        end else if (accept) begin
          state_next = TWO;
          skid_load  = 1'b1;
        end else if (release_main) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        // ready_o is low here, so the only possible move is draining the skid entry
        if (release_main) begin
          state_next     = ONE;
          main_load      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (!pwrEn_i) begin
      state_q <= EMPTY;
`ifdef SIM
      main_q  <= 'x;
      skid_q  <= 'x;
`endif
    end else if (flush_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_next;
      if (main_load)
        main_q <= main_from_skid ? skid_q : data_i;
      if (skid_load)
        skid_q <= data_i;
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer (WIDTH=8): directed scenarios then random
// traffic, all compared against a FIFO-queue reference model of at most two entries.
module tb_pipe_skid_buffer;

  logic       clk;
  logic       reset;
  logic       pwr_en;
  logic       flush;
  logic       valid_in;
  logic [7:0] data_in;
  logic       ready_out;
  logic       valid_out;
  logic [7:0] data_out;
  logic       stall;
  logic [1:0] count_out;

  int unsigned check_count = 0;
  int unsigned pass_count  = 0;

  // Reference model: in-flight payloads in acceptance order, head first
  logic [7:0] model_q[$];
  bit         model_known = 0;
  bit         model_zero  = 0;

  pipe_skid_buffer #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .pwrEn_i (pwr_en),
    .flush_i (flush),
    .valid_i (valid_in),
    .data_i  (data_in),
    .ready_o (ready_out),
    .valid_o (valid_out),
    .data_o  (data_out),
    .stall_i (stall),
    .count_o (count_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic checkOutput();
    logic exp_valid;
    logic exp_ready;
    if (!model_known) return;
    exp_valid = pwr_en && (model_q.size() > 0);
    exp_ready = !reset && pwr_en && (model_q.size() < 2);
    check("valid_o", {7'd0, valid_out}, {7'd0, exp_valid});
    check("ready_o", {7'd0, ready_out}, {7'd0, exp_ready});
    check("count_o", {6'd0, count_out}, 8'(model_q.size()));
    if (exp_valid)
      check("data_o", data_out, model_q[0]);
    else if (model_zero && pwr_en)
      check("data_o_reset", data_out, 8'h00);
  endtask

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge
  task automatic applyStimulus(input logic r, input logic p, input logic f,
                               input logic v, input logic [7:0] d, input logic s);
    bit acc;
    bit rel;
    reset    = r;
    pwr_en   = p;
    flush    = f;
    valid_in = v;
    data_in  = d;
    stall    = s;
    #1;
    checkOutput();
    acc = v && !r && p && (model_q.size() < 2);
    rel = p && (model_q.size() > 0) && !s;
    @(posedge clk);
    if (r) begin
      model_q.delete();
      model_known = 1;
      model_zero  = 1;
    end else if (!p) begin
      model_q.delete();
      model_zero = 0;
    end else if (f) begin
      model_q.delete();
    end else begin
      if (rel) void'(model_q.pop_front());
      if (acc) begin
        model_q.push_back(d);
        model_zero = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1; pwr_en = 1; flush = 0; valid_in = 0; data_in = 0; stall = 0;
    @(negedge clk);

    $display("[TB] reset with payload offered");
    applyStimulus(1, 1, 0, 1, 8'hAA, 0);
    applyStimulus(1, 1, 0, 1, 8'hAA, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);

    $display("[TB] streaming");
    for (int i = 1; i <= 4; i++) applyStimulus(0, 1, 0, 1, 8'(i), 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);

    $display("[TB] skid under stall");
    applyStimulus(0, 1, 0, 1, 8'h10, 1);
    applyStimulus(0, 1, 0, 1, 8'h11, 1);
    applyStimulus(0, 1, 0, 1, 8'h12, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);

    $display("[TB] flush from TWO");
    applyStimulus(0, 1, 0, 1, 8'h20, 1);
    applyStimulus(0, 1, 0, 1, 8'h21, 1);
    applyStimulus(0, 1, 1, 1, 8'h22, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);

    $display("[TB] power drop from TWO");
    applyStimulus(0, 1, 0, 1, 8'h40, 1);
    applyStimulus(0, 1, 0, 1, 8'h41, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 8'h42, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);

    $display("[TB] simultaneous accept and release");
    applyStimulus(0, 1, 0, 1, 8'h30, 0);
    applyStimulus(0, 1, 0, 1, 8'h31, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);

    $display("[TB] reset mid-operation");
    applyStimulus(0, 1, 0, 1, 8'h50, 1);
    applyStimulus(0, 1, 0, 1, 8'h51, 1);
    applyStimulus(1, 1, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 59) == 0),
                    ($urandom_range(0, 24) != 0),
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 9) < 7),
                    8'($urandom),
                    ($urandom_range(0, 9) < 4));
    end
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);
    applyStimulus(0, 1, 0, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
